// File: rtl/intc_pkg.sv
// Shared constants and types for the interrupt controller: register byte offsets,
// FSM state encoding and default source count.
package intc_pkg;
    localparam int INTC_N_SRC = 5;
    localparam int INTC_ID_W  = 3;

    localparam logic [4:0] INTC_MASK = 5'h00;
    localparam logic [4:0] INTC_PEND = 5'h04;
    localparam logic [4:0] INTC_MODE = 5'h08;
    localparam logic [4:0] INTC_INSV = 5'h0C;
    localparam logic [4:0] INTC_EOI  = 5'h10;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_SERVICE} intc_state_t;

    // Registers are word-aligned; bits [4:2] of the byte offset select one.
    function automatic logic [2:0] reg_idx(input logic [4:0] off);
        return off[4:2];
    endfunction
endpackage

// File: rtl/intc_prio_enc.sv
// Fixed-priority encoder: lowest set bit wins, valid when any request is set.
module intc_prio_enc #(
    parameter int N_SRC = 5,
    parameter int ID_W  = 3
) (
    input  logic [N_SRC-1:0] req,
    output logic [ID_W-1:0]  id,
    output logic             valid
);
    always_comb begin
        id = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) id = ID_W'(i);
        end
    end

    assign valid = |req;
endmodule

// File: rtl/interrupt_controller.sv
// Memory-mapped interrupt controller: mask/mode/pending per source, single prioritised
// request to the core, in-service tracking released by EOI. INTC_SYNC_EN adds a 2-flop input synchroniser.
module interrupt_controller
    import intc_pkg::*;
#(
    parameter int N_SRC = INTC_N_SRC,
    parameter int ID_W  = INTC_ID_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] i_interruption,
    input  logic             i_bus_wr,
    input  logic             i_bus_rd,
    input  logic [4:0]       i_bus_addr,
    input  logic [31:0]      i_bus_wdata,
    output logic [31:0]      o_bus_rdata,
    output logic             o_irq,
    output logic [ID_W-1:0]  o_irq_id,
    input  logic             i_ack
);
    intc_state_t      state;
    logic [N_SRC-1:0] src, hist, pend, mask, mode, insv;
    logic [N_SRC-1:0] rise, w1c, ack_oh, pend_nxt, eligible;
    logic [ID_W-1:0]  enc_id;
    logic             enc_vld, ack_take;
    logic [2:0]       sel;
    logic             wr_mask, wr_pend, wr_mode, wr_eoi;
    logic             unused_ok;

`ifdef INTC_SYNC_EN
    logic [N_SRC-1:0] sync1, sync2;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= i_interruption;
            sync2 <= sync1;
        end
    end
    assign src = sync2;
`else
    assign src = i_interruption;
`endif

    assign sel     = i_bus_addr[4:2];
    assign wr_mask = i_bus_wr && (sel == reg_idx(INTC_MASK));
    assign wr_pend = i_bus_wr && (sel == reg_idx(INTC_PEND));
    assign wr_mode = i_bus_wr && (sel == reg_idx(INTC_MODE));
    assign wr_eoi  = i_bus_wr && (sel == reg_idx(INTC_EOI));
    assign unused_ok = &{1'b0, i_bus_addr[1:0], i_bus_wdata[31:N_SRC]};

    assign rise     = src & ~hist;
    assign ack_take = (state == ST_REQ) && i_ack;
    assign ack_oh   = ack_take ? (N_SRC'(1) << o_irq_id) : '0;
    assign w1c      = wr_pend ? i_bus_wdata[N_SRC-1:0] : '0;
    // Edge bits: a new rising edge beats any clear in the same cycle. Level bits track the input.
    assign pend_nxt = (mode & (rise | (pend & ~(w1c | ack_oh)))) | (~mode & src);
    assign eligible = pend & mask;

    intc_prio_enc #(.N_SRC(N_SRC), .ID_W(ID_W)) u_enc (
        .req   (eligible),
        .id    (enc_id),
        .valid (enc_vld)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist <= '0;
            pend <= '0;
            mask <= '0;
            mode <= '1;
        end else begin
            hist <= src;
            pend <= pend_nxt;
            if (wr_mask) mask <= i_bus_wdata[N_SRC-1:0];
            if (wr_mode) mode <= i_bus_wdata[N_SRC-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            o_irq    <= 1'b0;
            o_irq_id <= '0;
            insv     <= '0;
        end else begin
            case (state)
                ST_IDLE: if (enc_vld) begin
                    state    <= ST_REQ;
                    o_irq    <= 1'b1;
                    o_irq_id <= enc_id;
                end
                ST_REQ: begin
                    // The core acknowledged the id it saw, so an ack wins over a vanishing request.
                    if (i_ack) begin
                        state <= ST_SERVICE;
                        o_irq <= 1'b0;
                        insv  <= ack_oh;
                    end else if (!enc_vld) begin
                        state <= ST_IDLE;
                        o_irq <= 1'b0;
                    end else begin
                        o_irq_id <= enc_id;
                    end
                end
                ST_SERVICE: if (wr_eoi) begin
                    state <= ST_IDLE;
                    insv  <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                    o_irq <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_bus_rdata <= '0;
        end else if (i_bus_rd) begin
            case (sel)
                reg_idx(INTC_MASK): o_bus_rdata <= 32'(mask);
                reg_idx(INTC_PEND): o_bus_rdata <= 32'(pend);
                reg_idx(INTC_MODE): o_bus_rdata <= 32'(mode);
                reg_idx(INTC_INSV): o_bus_rdata <= 32'(insv);
                default:            o_bus_rdata <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: register reads are scoreboarded
// (expected pushed at the read strobe, popped when rdata updates); irq lines checked at fixed latencies.
module tb_interrupt_controller;
    localparam int N_SRC = 5;
    localparam int ID_W  = 3;
`ifdef INTC_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [N_SRC-1:0] i_interruption;
    logic             i_bus_wr, i_bus_rd, i_ack;
    logic [4:0]       i_bus_addr;
    logic [31:0]      i_bus_wdata, o_bus_rdata;
    logic             o_irq;
    logic [ID_W-1:0]  o_irq_id;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    interrupt_controller #(.N_SRC(N_SRC), .ID_W(ID_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .i_interruption (i_interruption),
        .i_bus_wr       (i_bus_wr),
        .i_bus_rd       (i_bus_rd),
        .i_bus_addr     (i_bus_addr),
        .i_bus_wdata    (i_bus_wdata),
        .o_bus_rdata    (o_bus_rdata),
        .o_irq          (o_irq),
        .o_irq_id       (o_irq_id),
        .i_ack          (i_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_irq(input string tag, input logic irq, input logic [ID_W-1:0] id);
        chk({tag, ".irq"}, 32'(o_irq), 32'(irq));
        if (irq) chk({tag, ".id"}, 32'(o_irq_id), 32'(id));
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] data);
        i_bus_wr    = 1'b1;
        i_bus_addr  = addr;
        i_bus_wdata = data;
        tick();
        i_bus_wr    = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        i_bus_rd   = 1'b1;
        i_bus_addr = addr;
        tick();
        i_bus_rd   = 1'b0;
        chk(tag_q.pop_front(), o_bus_rdata, exp_q.pop_front());
    endtask

    task automatic pulse(input logic [N_SRC-1:0] s);
        i_interruption = s;
        tick();
        i_interruption = '0;
        repeat (SYNC) tick();
    endtask

    task automatic ack();
        i_ack = 1'b1;
        tick();
        i_ack = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        i_interruption = '0;
        i_bus_wr = 0; i_bus_rd = 0; i_ack = 0;
        i_bus_addr = '0; i_bus_wdata = '0;
        repeat (2) tick();
        reset = 1'b0;

        // reset state
        chk_irq("rst", 1'b0, '0);
        chk("rst.id", 32'(o_irq_id), 32'd0);
        chk("rst.rdata", o_bus_rdata, 32'd0);
        rd("rst.mode", 5'h08, 32'h1F);
        rd("rst.mask", 5'h00, 32'h0);
        rd("rst.pend", 5'h04, 32'h0);

        // 1: single masked-in edge source, full ack/EOI cycle
        wr(5'h00, 32'h04);
        pulse(5'b00100);
        chk_irq("t1.early", 1'b0, '0);
        tick();
        chk_irq("t1.req", 1'b1, 3'd2);
        ack();
        chk_irq("t1.ack", 1'b0, '0);
        rd("t1.insv", 5'h0C, 32'h04);
        rd("t1.pend", 5'h04, 32'h00);
        wr(5'h10, 32'h0);
        rd("t1.insv_eoi", 5'h0C, 32'h00);
        rd("t1.eoi_rd", 5'h10, 32'h00);

        // 2: simultaneous sources, priority then re-issue after EOI
        wr(5'h00, 32'h1F);
        pulse(5'b01010);
        tick();
        chk_irq("t2.req", 1'b1, 3'd1);
        ack();
        chk_irq("t2.ack", 1'b0, '0);
        rd("t2.pend", 5'h04, 32'h08);
        wr(5'h10, 32'h0);
        chk_irq("t2.eoi", 1'b0, '0);
        tick();
        chk_irq("t2.reissue", 1'b1, 3'd3);
        ack();
        wr(5'h10, 32'h0);

        // 3: higher priority arrives while in REQ
        pulse(5'b10000);
        tick();
        chk_irq("t3.req4", 1'b1, 3'd4);
        pulse(5'b00001);
        tick();
        chk_irq("t3.req0", 1'b1, 3'd0);
        ack();
        rd("t3.pend", 5'h04, 32'h10);
        rd("t3.insv", 5'h0C, 32'h01);
        wr(5'h10, 32'h0);
        tick();
        chk_irq("t3.req4b", 1'b1, 3'd4);
        ack();
        wr(5'h10, 32'h0);

        // 4: level mode, request withdrawn without ack
        wr(5'h08, 32'h00);
        wr(5'h00, 32'h01);
        i_interruption = 5'b00001;
        repeat (3) tick();
        i_interruption = '0;
        repeat (SYNC) tick();
        tick();
        chk_irq("t4.hold", 1'b1, 3'd0);
        tick();
        chk_irq("t4.drop", 1'b0, '0);
        wr(5'h08, 32'h1F);

        // 5: W1C loses to a same-cycle edge, then clears on its own
        wr(5'h00, 32'h04);
        i_interruption = 5'b00100;
        repeat (SYNC) tick();
        wr(5'h04, 32'h04);
        i_interruption = '0;
        tick();
        chk_irq("t5.req", 1'b1, 3'd2);
        rd("t5.pend", 5'h04, 32'h04);
        wr(5'h04, 32'h04);
        chk_irq("t5.w1c", 1'b1, 3'd2);
        tick();
        chk_irq("t5.drop", 1'b0, '0);
        rd("t5.pend0", 5'h04, 32'h00);

        // 6: asynchronous reset while in SERVICE
        pulse(5'b00100);
        tick();
        chk_irq("t6.req", 1'b1, 3'd2);
        ack();
        rd("t6.mask", 5'h00, 32'h04);
        #2 reset = 1'b1;
        #1;
        chk_irq("t6.rst", 1'b0, '0);
        chk("t6.rst.id", 32'(o_irq_id), 32'd0);
        chk("t6.rst.rdata", o_bus_rdata, 32'd0);
        #1 reset = 1'b0;
        tick();
        rd("t6.mask0", 5'h00, 32'h00);
        rd("t6.mode", 5'h08, 32'h1F);
        rd("t6.insv", 5'h0C, 32'h00);

        // same-cycle read and write returns the old value
        i_bus_rd = 1'b1;
        exp_q.push_back(32'h00);
        tag_q.push_back("rw.old");
        wr(5'h00, 32'h03);
        i_bus_rd = 1'b0;
        chk(tag_q.pop_front(), o_bus_rdata, exp_q.pop_front());
        rd("rw.new", 5'h00, 32'h03);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
